// File: rtl/ble_fec_pkg.sv
// rtl/ble_fec_pkg.sv - shared defaults, state encodings and syndrome table helper for the BLE FEC decoder
package ble_fec_pkg;

  localparam int DEF_N = 15;
  localparam int DEF_K = 10;
  localparam logic [DEF_N-DEF_K:0] DEF_GEN_POLY = 6'b110101;

  typedef enum logic [1:0] {
    RX_FILL = 2'd0,
    RX_FULL = 2'd1,
    RX_XFER = 2'd2
  } rx_state_t;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_DRAIN = 1'b1
  } out_state_t;

  // Syndrome produced by a lone error at codeword position pos: x^(n-1-pos) mod g.
  function automatic logic [31:0] syn_of_pos(
    input int          pos,
    input int          n  = DEF_N,
    input int          r  = DEF_N - DEF_K,
    input logic [31:0] gp = 32'(DEF_GEN_POLY)
  );
    logic [31:0] mask;
    logic [31:0] s;
    logic        msb;
    mask = (32'd1 << r) - 32'd1;
    s    = 32'd1 & mask;
    for (int j = 0; j < n - 1 - pos; j++) begin
      msb = s[r-1];
      s   = (s << 1) & mask;
      if (msb) s = s ^ (gp & mask);
    end
    return s;
  endfunction

endpackage

// File: rtl/ble_fec_syndrome_lfsr.sv
// rtl/ble_fec_syndrome_lfsr.sv - serial polynomial divider, first bit is the highest-degree coefficient
module ble_fec_syndrome_lfsr #(
  parameter int         R    = 5,
  parameter logic [R:0] POLY = 6'b110101
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [R-1:0] syndrome
);

  logic [R-1:0] base;
  logic [R:0]   shifted;
  logic [R-1:0] next;

  // Clear and shift may coincide: the new bit then starts a fresh division.
  always_comb begin
    base    = clr ? '0 : syndrome;
    shifted = {base, din};
    next    = base;
    if (en) begin
      next = shifted[R-1:0] ^ (base[R-1] ? POLY[R-1:0] : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syndrome <= '0;
    end else begin
      syndrome <= next;
    end
  end

endmodule

// File: rtl/ble_hamming_dec_param.sv
// rtl/ble_hamming_dec_param.sv - bit-serial shortened cyclic Hamming decoder with a one-codeword output bank
// Error statistics counters are built only when HAMMING_DEC_STATS_EN is defined.
module ble_hamming_dec_param
  import ble_fec_pkg::*;
#(
  parameter int           N        = DEF_N,
  parameter int           K        = DEF_K,
  parameter logic [N-K:0] GEN_POLY = DEF_GEN_POLY,
  parameter int           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             data_in,
  output logic             in_ready,
  output logic             valid_out,
  output logic             data_out,
  input  logic             out_ready,
  output logic             finished,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic             overflow,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  rx_state_t  rx_state, rx_next;
  out_state_t out_state, out_next;

  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] wr_idx;
  logic [K-1:0]  cw_data;
  logic [R-1:0]  syndrome;
  logic [KW-1:0] out_idx;
  logic [K-1:0]  bank;
  logic [K-1:0]  flip_mask;
  logic [K-1:0]  data_fixed;
  logic [5:0]    match_cnt;
  logic          single_err, uncorr_err;
  logic          accept, last_bit, xfer;
  logic          out_fire, out_last, bank_free;

  logic [R-1:0] syn_tab [N];
  for (genvar p = 0; p < N; p++) begin : g_tab
    localparam logic [R-1:0] SYN = R'(syn_of_pos(p, N, R, 32'(GEN_POLY)));
    assign syn_tab[p] = SYN;
  end

  assign in_ready  = (rx_state != RX_FULL);
  assign xfer      = (rx_state == RX_XFER);
  assign accept    = valid_in && in_ready;
  assign last_bit  = accept && (rx_state == RX_FILL) && (bit_cnt == CW'(N - 1));
  assign wr_idx    = xfer ? '0 : bit_cnt;
  assign valid_out = (out_state == OUT_DRAIN);
  assign data_out  = bank[out_idx];
  assign finished  = valid_out && (out_idx == KW'(K - 1));
  assign out_fire  = valid_out && out_ready;
  assign out_last  = out_fire && (out_idx == KW'(K - 1));
  // A bank draining its last bit this cycle counts as free so XFER follows immediately.
  assign bank_free = (out_state == OUT_IDLE) || out_last;

  ble_fec_syndrome_lfsr #(
    .R    (R),
    .POLY (GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .clr      (xfer),
    .en       (accept),
    .din      (data_in),
    .syndrome (syndrome)
  );

  // Parity positions still take part in match counting; only data positions can be flipped.
  always_comb begin
    match_cnt = '0;
    flip_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (syndrome == syn_tab[i]) match_cnt = match_cnt + 6'd1;
    end
    for (int i = 0; i < K; i++) begin
      flip_mask[i] = (syndrome == syn_tab[i]);
    end
    single_err = (syndrome != '0) && (match_cnt == 6'd1);
    uncorr_err = (syndrome != '0) && !single_err;
    data_fixed = single_err ? (cw_data ^ flip_mask) : cw_data;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_FILL: if (last_bit) rx_next = bank_free ? RX_XFER : RX_FULL;
      RX_FULL: if (bank_free) rx_next = RX_XFER;
      RX_XFER: rx_next = RX_FILL;
      default: rx_next = RX_FILL;
    endcase
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      OUT_IDLE:  if (xfer) out_next = OUT_DRAIN;
      OUT_DRAIN: if (out_last && !xfer) out_next = OUT_IDLE;
      default:   out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_FILL;
      out_state <= OUT_IDLE;
    end else begin
      rx_state  <= rx_next;
      out_state <= out_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt           <= '0;
      cw_data           <= '0;
      bank              <= '0;
      out_idx           <= '0;
      overflow          <= 1'b0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      if (accept && (wr_idx < CW'(K))) cw_data[wr_idx] <= data_in;
      if (xfer) begin
        bit_cnt <= accept ? CW'(1) : '0;
      end else if (accept && !last_bit) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (xfer) begin
        bank    <= data_fixed;
        out_idx <= '0;
      end else if (out_fire) begin
        out_idx <= out_last ? '0 : out_idx + KW'(1);
      end
      if (valid_in && !in_ready) overflow <= 1'b1;
      err_corrected     <= xfer && single_err;
      err_uncorrectable <= xfer && uncorr_err;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else begin
      if (xfer && single_err && (cnt_corrected != '1)) begin
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      end
      if (xfer && uncorr_err && (cnt_uncorrectable != '1)) begin
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
      end
    end
  end
`else
  assign cnt_corrected     = '0;
  assign cnt_uncorrectable = '0;
`endif

endmodule

// File: tb/tb_ble_hamming_dec_param.sv
// tb/tb_ble_hamming_dec_param.sv - directed and random self-checking bench for ble_hamming_dec_param
module tb_ble_hamming_dec_param;

  localparam int N = 15;
  localparam int K = 10;
  localparam int R = 5;
  localparam logic [R-1:0] G_LOW = 5'b10101;
  // Hand-derived codewords: data 1 (bit 0) and data 2 (bit 1), and their sum (data 3).
  localparam logic [N-1:0] CW_D1 = 15'b010110000000001;
  localparam logic [N-1:0] CW_D2 = 15'b101100000000010;
  localparam logic [N-1:0] CW_D3 = 15'b111010000000011;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        data_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, valid_out, data_out, finished;
  logic        err_corrected, err_uncorrectable, overflow;
  logic [15:0] cnt_corrected, cnt_uncorrectable;

  int   tests = 0;
  int   fails = 0;
  int   n_corr = 0;
  int   n_unc = 0;
  bit   rand_ready = 1'b0;
  logic out_q[$];
  logic fin_q[$];
  logic exp_q[$];

  ble_hamming_dec_param dut (
    .clk               (clk),
    .reset             (reset),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .in_ready          (in_ready),
    .valid_out         (valid_out),
    .data_out          (data_out),
    .out_ready         (out_ready),
    .finished          (finished),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .overflow          (overflow),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out && out_ready) begin
      out_q.push_back(data_out);
      fin_q.push_back(finished);
    end
    if (err_corrected) n_corr++;
    if (err_uncorrectable) n_unc++;
  end

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [R-1:0] s;
    logic [N-1:0] c;
    logic         fb;
    s = '0;
    c = '0;
    for (int i = 0; i < K; i++) c[i] = d[i];
    for (int i = 0; i < N; i++) begin
      fb = s[R-1];
      s  = {s[R-2:0], (i < K) ? d[i] : 1'b0};
      if (fb) s = s ^ G_LOW;
    end
    for (int j = 0; j < R; j++) c[K+j] = s[R-1-j];
    return c;
  endfunction

  function automatic logic [K-1:0] got_word(input int base);
    logic [K-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++) if (base + i < out_q.size()) w[i] = out_q[base+i];
    return w;
  endfunction

  function automatic logic [K-1:0] fin_word(input int base);
    logic [K-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++) if (base + i < fin_q.size()) w[i] = fin_q[base+i];
    return w;
  endfunction

  task automatic clear_obs();
    out_q.delete();
    fin_q.delete();
    exp_q.delete();
    n_corr = 0;
    n_unc  = 0;
  endtask

  task automatic drive_cycle(input logic v, input logic b);
    valid_in = v;
    data_in  = b;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] cw, input bit gaps);
    int guard;
    for (int i = 0; i < N; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) drive_cycle(1'b0, 1'b0);
      guard = 0;
      while (!in_ready && guard < 200) begin
        drive_cycle(1'b0, 1'b0);
        guard++;
      end
      if (guard >= 200) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
      end
      drive_cycle(1'b1, cw[i]);
    end
  endtask

  task automatic wait_out(input int n);
    int guard;
    guard = 0;
    while (out_q.size() < n && guard < 5000) begin
      drive_cycle(1'b0, 1'b0);
      guard++;
    end
    repeat (2) drive_cycle(1'b0, 1'b0);
    tests++;
    if (out_q.size() !== n) begin
      fails++;
      $display("FAIL out_count: got %0d bits, required %0d", out_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, valid_out, data_out, finished, err_corrected, err_uncorrectable, overflow} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {in_ready, valid_out, data_out, finished, err_corrected, err_uncorrectable, overflow});
    end
    tests++;
    if (cnt_corrected !== 16'd0 || cnt_uncorrectable !== 16'd0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", cnt_corrected, cnt_uncorrectable);
    end
    apply_reset();
    tests++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: in_ready=%b valid_out=%b required 1/0", in_ready, valid_out);
    end
  endtask

  task automatic test_all_zero();
    clear_obs();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) drive_cycle(1'b1, 1'b0);
    tests++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL xfer_cycle: valid_out=%b in_ready=%b required 0/1", valid_out, in_ready);
    end
    drive_cycle(1'b0, 1'b0);
    tests++;
    if (valid_out !== 1'b1) begin
      fails++;
      $display("FAIL first_latency: valid_out=%b required 1 two cycles after last bit", valid_out);
    end
    wait_out(K);
    tests++;
    if (got_word(0) !== 10'b0) begin
      fails++;
      $display("FAIL zero_data: got %b required %b", got_word(0), 10'b0);
    end
    tests++;
    if (fin_word(0) !== 10'b1000000000) begin
      fails++;
      $display("FAIL zero_finished: got %b required %b", fin_word(0), 10'b1000000000);
    end
    tests++;
    if (n_corr !== 0 || n_unc !== 0) begin
      fails++;
      $display("FAIL zero_err: got corr=%0d unc=%0d required 0/0", n_corr, n_unc);
    end
  endtask

  task automatic test_single_error();
    clear_obs();
    out_ready = 1'b1;
    send_word(15'b000000000001000, 1'b0);
    wait_out(K);
    tests++;
    if (got_word(0) !== 10'b0) begin
      fails++;
      $display("FAIL single_data: got %b required %b", got_word(0), 10'b0);
    end
    tests++;
    if (n_corr !== 1 || n_unc !== 0) begin
      fails++;
      $display("FAIL single_pulse: got corr=%0d unc=%0d required 1/0", n_corr, n_unc);
    end
    tests++;
    if (cnt_corrected !== (STATS ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL single_cnt: got %0d required %0d", cnt_corrected, STATS ? 1 : 0);
    end
  endtask

  task automatic test_double_error();
    clear_obs();
    out_ready = 1'b1;
    send_word(15'b000000000000011, 1'b0);
    wait_out(K);
    tests++;
    if (got_word(0) !== 10'b0000000011) begin
      fails++;
      $display("FAIL double_data: got %b required %b", got_word(0), 10'b0000000011);
    end
    tests++;
    if (n_unc !== 1 || n_corr !== 0) begin
      fails++;
      $display("FAIL double_pulse: got corr=%0d unc=%0d required 0/1", n_corr, n_unc);
    end
    tests++;
    if (cnt_uncorrectable !== (STATS ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL double_cnt: got %0d required %0d", cnt_uncorrectable, STATS ? 1 : 0);
    end
  endtask

  task automatic test_known_codeword();
    clear_obs();
    out_ready = 1'b1;
    send_word(CW_D1, 1'b0);
    send_word(CW_D1 ^ 15'b001000000000000, 1'b0);
    wait_out(2 * K);
    tests++;
    if (got_word(0) !== 10'b0000000001 || got_word(K) !== 10'b0000000001) begin
      fails++;
      $display("FAIL known_data: got %b %b required %b %b", got_word(0), got_word(K),
               10'b0000000001, 10'b0000000001);
    end
    tests++;
    if (n_corr !== 1 || n_unc !== 0) begin
      fails++;
      $display("FAIL known_pulse: got corr=%0d unc=%0d required 1/0", n_corr, n_unc);
    end
    tests++;
    if (cnt_corrected !== (STATS ? 16'd2 : 16'd0)) begin
      fails++;
      $display("FAIL known_cnt: got %0d required %0d", cnt_corrected, STATS ? 2 : 0);
    end
  endtask

  task automatic test_random();
    logic [K-1:0] d;
    logic [N-1:0] cw;
    int           bad;
    int           first_bad;
    int           fin_bad;
    apply_reset();
    rand_ready = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      d  = K'($urandom);
      cw = encode(d) ^ (15'd1 << $urandom_range(0, N - 1));
      for (int i = 0; i < K; i++) exp_q.push_back(d[i]);
      send_word(cw, 1'b1);
    end
    wait_out(1000 * K);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    bad = 0;
    first_bad = -1;
    fin_bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      if (i < fin_q.size() && fin_q[i] !== ((i % K) == K - 1)) fin_bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL random_data: %0d wrong bits (first at %0d), required 0", bad, first_bad);
    end
    tests++;
    if (fin_bad !== 0) begin
      fails++;
      $display("FAIL random_finished: %0d misplaced flags, required 0", fin_bad);
    end
    tests++;
    if (n_corr !== 1000 || n_unc !== 0) begin
      fails++;
      $display("FAIL random_pulses: got corr=%0d unc=%0d required 1000/0", n_corr, n_unc);
    end
    tests++;
    if (cnt_corrected !== (STATS ? 16'd1000 : 16'd0)) begin
      fails++;
      $display("FAIL random_cnt: got %0d required %0d", cnt_corrected, STATS ? 1000 : 0);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL random_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b0;
    send_word(CW_D1, 1'b0);
    send_word(CW_D3, 1'b0);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_in_ready: got %b required 0", in_ready);
    end
    drive_cycle(1'b1, 1'b1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %b required 1", overflow);
    end
    repeat (3) drive_cycle(1'b0, 1'b0);
    tests++;
    if (valid_out !== 1'b1 || data_out !== 1'b1 || finished !== 1'b0 || out_q.size() !== 0) begin
      fails++;
      $display("FAIL held_output: valid=%b data=%b fin=%b taken=%0d required 1/1/0/0",
               valid_out, data_out, finished, out_q.size());
    end
    out_ready = 1'b1;
    wait_out(2 * K);
    tests++;
    if (got_word(0) !== 10'b0000000001 || got_word(K) !== 10'b0000000011) begin
      fails++;
      $display("FAIL b2b_data: got %b %b required %b %b", got_word(0), got_word(K),
               10'b0000000001, 10'b0000000011);
    end
    tests++;
    if (in_ready !== 1'b1 || overflow !== 1'b1 || n_corr !== 0 || n_unc !== 0) begin
      fails++;
      $display("FAIL b2b_state: in_ready=%b overflow=%b corr=%0d unc=%0d required 1/1/0/0",
               in_ready, overflow, n_corr, n_unc);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, CW_D1[i]);
    reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, valid_out, data_out, finished, err_corrected, err_uncorrectable, overflow} !== 7'b1000000) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b required 1000000",
               {in_ready, valid_out, data_out, finished, err_corrected, err_uncorrectable, overflow});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
    send_word(CW_D2, 1'b0);
    wait_out(K);
    tests++;
    if (got_word(0) !== 10'b0000000010 || n_corr !== 0 || n_unc !== 0) begin
      fails++;
      $display("FAIL mid_reset_next: got %b corr=%0d unc=%0d required %b 0/0",
               got_word(0), n_corr, n_unc, 10'b0000000010);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_error();
    test_double_error();
    test_known_codeword();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
